rca_fault_scanner: RTL and testbench

- Sequential self-test stage wrapped around a combinational 4-bit ripple-carry adder under test (DUT).
- Upstream role: drives every operand combination (a, b, cin) into the DUT.
- Downstream role: consumes the DUT's sum/cout and compares them against a golden a+b+cin.
- Reports pass/fail, a mismatch count and the first failing vector, so faulty adder variants are diagnosed on-board without a simulator.

---
 rtl/rca_fault_scanner_pkg.sv | 24 ++
 rtl/rca_fault_scanner_if.sv | 16 +
 rtl/rca_fault_scanner_golden.sv | 16 +
 rtl/rca_fault_scanner.sv | 148 ++++++++++++++
 tb/tb_rca_fault_scanner.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rca_fault_scanner_pkg.sv
// Shared widths, state encoding and vector layout for the adder fault scanner.
package rca_fault_scanner_pkg;

  localparam int unsigned VEC_W       = 9;
  localparam int unsigned OPW         = 4;
  localparam int unsigned RES_W       = 5;
  localparam int unsigned NUM_VECTORS = 512;
  localparam int unsigned CNT_W       = 10;
  localparam int unsigned SETTLE_W    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Vector layout {cin, a, b}; bit 8 is cin, matching the reported fail_vec.
  typedef struct packed {
    logic           cin;
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
  } vec_t;

endpackage

// File: rtl/rca_fault_scanner_if.sv
// Operand/result bus between the scanner and the adder under test.
interface rca_fault_scanner_if;
  import rca_fault_scanner_pkg::*;

  logic [OPW-1:0] a;
  logic [OPW-1:0] b;
  logic           cin;
  logic [OPW-1:0] sum;
  logic           cout;

  // Scanner side drives operands and reads the response.
  modport master (output a, output b, output cin, input sum, input cout);
  // Adder side reads operands and drives the response.
  modport slave  (input a, input b, input cin, output sum, output cout);

endinterface

// File: rtl/rca_fault_scanner_golden.sv
// Behavioural reference adder: expected = a + b + cin, zero-extended to 5 bits.
module rca_golden_model
  import rca_fault_scanner_pkg::*;
(
  input  logic [OPW-1:0]   a,
  input  logic [OPW-1:0]   b,
  input  logic             cin,
  output logic [RES_W-1:0] expected
);

  // Golden sum computed at full result width so the carry lands in bit 4.
  always_comb begin
    expected = RES_W'(a) + RES_W'(b) + RES_W'(cin);
  end

endmodule

// File: rtl/rca_fault_scanner.sv
// Exhaustive self-test of a 4-bit adder: sweeps all {cin,a,b}, compares the
// response against the golden model and records count and first failure.
module rca_fault_scanner
  import rca_fault_scanner_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter bit          STOP_ON_FAIL  = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  rca_fault_scanner_if.master dut,
  output logic                busy,
  output logic                done,
  output logic                fail,
  output logic [CNT_W-1:0]    fail_count,
  output logic [VEC_W-1:0]    fail_vec,
  output logic [RES_W-1:0]    fail_got
);

  state_e              state_q, state_d;
  logic [VEC_W-1:0]    vec_q, vec_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                fail_q, fail_d;
  logic [CNT_W-1:0]    fail_count_q, fail_count_d;
  logic [VEC_W-1:0]    fail_vec_q, fail_vec_d;
  logic [RES_W-1:0]    fail_got_q, fail_got_d;

  vec_t                cur_vec;
  logic [RES_W-1:0]    expected;
  logic [RES_W-1:0]    got_c;
  logic                sample_c;
  logic                mismatch_c;
  logic                last_c;

  // Operands come straight from the vector register.
  assign cur_vec = vec_t'(vec_q);
  assign dut.a   = cur_vec.a;
  assign dut.b   = cur_vec.b;
  assign dut.cin = cur_vec.cin;

  rca_golden_model u_golden (
    .a        (cur_vec.a),
    .b        (cur_vec.b),
    .cin      (cur_vec.cin),
    .expected (expected)
  );

  // Response is judged only on the last settle cycle of each vector.
  assign got_c      = {dut.cout, dut.sum};
  assign sample_c   = (settle_q == SETTLE_W'(SETTLE_CYCLES - 1));
  assign mismatch_c = sample_c && (got_c != expected);
  assign last_c     = (vec_q == VEC_W'(NUM_VECTORS - 1));

  // Next-state, vector sequencing and result capture.
  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    settle_d     = settle_q;
    busy_d       = busy_q;
    done_d       = done_q;
    fail_d       = fail_q;
    fail_count_d = fail_count_q;
    fail_vec_d   = fail_vec_q;
    fail_got_d   = fail_got_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d      = APPLY;
          vec_d        = '0;
          settle_d     = '0;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          fail_d       = 1'b0;
          fail_count_d = '0;
          fail_vec_d   = '0;
          fail_got_d   = '0;
        end
      end

      APPLY: begin
        if (sample_c) begin
          if (mismatch_c) begin
            fail_count_d = fail_count_q + CNT_W'(1);
            fail_d       = 1'b1;
            if (!fail_q) begin
              fail_vec_d = vec_q;
              fail_got_d = got_c;
            end
          end
          settle_d = '0;
          // The last vector stays on the bus in DONE; never wrap to 0.
          if (last_c || (STOP_ON_FAIL && mismatch_c)) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            vec_d = vec_q + VEC_W'(1);
          end
        end else begin
          settle_d = settle_q + SETTLE_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State and result registers; reset abandons any scan in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      vec_q        <= '0;
      settle_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      fail_count_q <= '0;
      fail_vec_q   <= '0;
      fail_got_q   <= '0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      settle_q     <= settle_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      fail_count_q <= fail_count_d;
      fail_vec_q   <= fail_vec_d;
      fail_got_q   <= fail_got_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign fail       = fail_q;
  assign fail_count = fail_count_q;
  assign fail_vec   = fail_vec_q;
  assign fail_got   = fail_got_q;

endmodule

// File: tb/tb_rca_fault_scanner.sv
// Scoreboard bench: three scanner instances (SETTLE/STOP variants) around a
// configurable behavioural adder with injectable faults.
module tb_rca_fault_scanner;
  import rca_fault_scanner_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic             start      [3];
  logic             busy       [3];
  logic             done       [3];
  logic             fail       [3];
  logic [CNT_W-1:0] fail_count [3];
  logic [VEC_W-1:0] fail_vec   [3];
  logic [RES_W-1:0] fail_got   [3];
  logic [VEC_W-1:0] dvec       [3];
  int unsigned      fault_mode [3];

  rca_fault_scanner_if bus [3] ();

  // Adder under test: 0 good, 1 cout=c3&c4, 2 sum[0] stuck at 0.
  for (genvar g = 0; g < 3; g++) begin : g_adder
    logic [4:0] full;
    logic [3:0] low;
    always_comb begin
      full = 5'(bus[g].a) + 5'(bus[g].b) + 5'(bus[g].cin);
      low  = 4'(bus[g].a[2:0]) + 4'(bus[g].b[2:0]) + 4'(bus[g].cin);
      bus[g].sum  = full[3:0];
      bus[g].cout = full[4];
      if (fault_mode[g] == 1) bus[g].cout = low[3] & full[4];
      if (fault_mode[g] == 2) bus[g].sum  = {full[3:1], 1'b0};
    end
    assign dvec[g] = {bus[g].cin, bus[g].a, bus[g].b};
  end

  rca_fault_scanner #(.SETTLE_CYCLES(1), .STOP_ON_FAIL(1'b0)) u_scan0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .dut(bus[0]),
    .busy(busy[0]), .done(done[0]), .fail(fail[0]),
    .fail_count(fail_count[0]), .fail_vec(fail_vec[0]), .fail_got(fail_got[0]));

  rca_fault_scanner #(.SETTLE_CYCLES(1), .STOP_ON_FAIL(1'b1)) u_scan1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .dut(bus[1]),
    .busy(busy[1]), .done(done[1]), .fail(fail[1]),
    .fail_count(fail_count[1]), .fail_vec(fail_vec[1]), .fail_got(fail_got[1]));

  rca_fault_scanner #(.SETTLE_CYCLES(3), .STOP_ON_FAIL(1'b0)) u_scan2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .dut(bus[2]),
    .busy(busy[2]), .done(done[2]), .fail(fail[2]),
    .fail_count(fail_count[2]), .fail_vec(fail_vec[2]), .fail_got(fail_got[2]));

  typedef struct {
    int unsigned inst;
    int unsigned fail;
    int unsigned count;
    int unsigned fvec;
    int unsigned fgot;
    int unsigned last;
    int unsigned busy_cycles;
  } exp_t;

  exp_t sb_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(string name, int inst, int unsigned act, int unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s[u%0d]: got 0x%0h expected 0x%0h", name, inst, act, exp);
    end
  endtask

  function automatic int unsigned settle_of(int i);
    return (i == 2) ? 3 : 1;
  endfunction

  // Monitor: counts busy cycles, checks per-vector hold time, and pops the
  // scoreboard whenever an instance raises done.
  int unsigned      busy_cnt  [3];
  int unsigned      run_len   [3];
  int unsigned      hold_bad  [3];
  logic             prev_busy [3];
  logic             done_prev [3];
  logic [VEC_W-1:0] prev_vec  [3];

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        busy_cnt[i]  = 0;
        run_len[i]   = 0;
        hold_bad[i]  = 0;
        prev_busy[i] = 1'b0;
        done_prev[i] = 1'b0;
        prev_vec[i]  = '0;
      end else begin
        if (busy[i]) begin
          if (prev_busy[i] && dvec[i] == prev_vec[i]) begin
            run_len[i]++;
          end else begin
            if (prev_busy[i] && run_len[i] != settle_of(i)) hold_bad[i]++;
            run_len[i] = 1;
          end
          busy_cnt[i]++;
        end else if (prev_busy[i] && run_len[i] != settle_of(i)) begin
          hold_bad[i]++;
        end
        if (done[i] && !done_prev[i]) begin
          if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done[u%0d]: got done with empty scoreboard expected none", i);
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("done_instance", i, i, e.inst);
            check("fail", i, 32'(fail[i]), e.fail);
            check("fail_count", i, 32'(fail_count[i]), e.count);
            check("fail_vec", i, 32'(fail_vec[i]), e.fvec);
            check("fail_got", i, 32'(fail_got[i]), e.fgot);
            check("last_vec", i, 32'(dvec[i]), e.last);
            check("busy_cycles", i, busy_cnt[i], e.busy_cycles);
            check("hold_violations", i, hold_bad[i], 0);
          end
          busy_cnt[i] = 0;
          hold_bad[i] = 0;
        end
        prev_busy[i] = busy[i];
        prev_vec[i]  = dvec[i];
        done_prev[i] = done[i];
      end
    end
  end

  task automatic push(int unsigned inst, int unsigned f, int unsigned cnt, int unsigned fv,
                      int unsigned fg, int unsigned last, int unsigned bc);
    exp_t e;
    e.inst = inst; e.fail = f; e.count = cnt; e.fvec = fv; e.fgot = fg;
    e.last = last; e.busy_cycles = bc;
    sb_q.push_back(e);
  endtask

  task automatic pulse_start(int i);
    @(negedge clk);
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  task automatic wait_done(int i, int unsigned budget);
    int unsigned n = 0;
    while (!done[i] && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done[i]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout[u%0d]: got no done after %0d cycles expected done", i, n);
    end
    @(negedge clk);
  endtask

  task automatic check_zero(int i, string tag);
    check({tag, "_busy"}, i, 32'(busy[i]), 0);
    check({tag, "_done"}, i, 32'(done[i]), 0);
    check({tag, "_fail"}, i, 32'(fail[i]), 0);
    check({tag, "_count"}, i, 32'(fail_count[i]), 0);
    check({tag, "_fvec"}, i, 32'(fail_vec[i]), 0);
    check({tag, "_fgot"}, i, 32'(fail_got[i]), 0);
    check({tag, "_dutvec"}, i, 32'(dvec[i]), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start[i]      = 1'b0;
      fault_mode[i] = 0;
    end
    fault_mode[1] = 2;
    #17;
    for (int i = 0; i < 3; i++) check_zero(i, "reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Good adder, full sweep: 512 busy cycles, no failures.
    push(0, 0, 0, 0, 0, 9'h1FF, 512);
    pulse_start(0);
    wait_done(0, 600);

    // cout fault, reset asserted mid-scan around cycle 200.
    fault_mode[0] = 1;
    pulse_start(0);
    repeat (199) @(negedge clk);
    check("pre_reset_fail", 0, 32'(fail[0]), 1);
    #2 rst_n = 1'b0;
    #1 check_zero(0, "midreset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Fresh cout-fault scan: 64 failures, first at a=8 b=8 cin=0.
    push(0, 1, 64, 9'h088, 0, 9'h1FF, 512);
    pulse_start(0);
    wait_done(0, 600);

    // Back-to-back restart from DONE clears results on entry.
    push(0, 1, 64, 9'h088, 0, 9'h1FF, 512);
    pulse_start(0);
    check("restart_fail_clr", 0, 32'(fail[0]), 0);
    check("restart_count_clr", 0, 32'(fail_count[0]), 0);
    wait_done(0, 600);

    // sum[0] stuck-at-0, full sweep: every odd sum fails (256), first at vec 1.
    fault_mode[0] = 2;
    push(0, 1, 256, 9'h001, 0, 9'h1FF, 512);
    pulse_start(0);
    wait_done(0, 600);

    // Stop-on-fail: halts on vector 1 with b=1 left on the bus.
    push(1, 1, 1, 9'h001, 0, 9'h001, 2);
    pulse_start(1);
    wait_done(1, 600);
    check("stop_dut_b", 1, 32'(bus[1].b), 1);
    check("stop_busy", 1, 32'(busy[1]), 0);

    // SETTLE=3 good adder; extra start pulses mid-scan must be ignored.
    push(2, 0, 0, 0, 0, 9'h1FF, 1536);
    pulse_start(2);
    repeat (100) @(negedge clk);
    pulse_start(2);
    repeat (500) @(negedge clk);
    pulse_start(2);
    wait_done(2, 1600);

    check("scoreboard_left", 0, sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
